// File: rtl/pda_dbg_pkg.sv
// Shared debug-controller types: FSM states, run modes and stop causes,
// plus a small helper that tells whether a state lets the core advance.
package pda_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_STEPPING = 2'b10,
      ST_HALTED   = 2'b11
   } run_state_e;

   typedef enum logic [1:0] {
      MODE_FREE  = 2'b00,
      MODE_LIMIT = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_BREAK = 2'b11
   } run_mode_e;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_LIMIT = 2'b01,
      CAUSE_BREAK = 2'b10,
      CAUSE_SAT   = 2'b11
   } stop_cause_e;

   // The core is released (halt low) only while running or stepping.
   function automatic logic is_running(input run_state_e st);
      return (st == ST_RUN) || (st == ST_STEPPING);
   endfunction

endpackage : pda_dbg_pkg

// File: rtl/pda_brk_match.sv
// Instruction breakpoint matcher: NBRK equality comparators against the
// fetched instruction, each gated by its enable, OR-reduced into one hit.
// Purely combinational; the run controller decides when a hit matters.
module pda_brk_match
   import pda_dbg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NBRK   = 2
) (
   input  logic [DATA_W-1:0]      inst,
   input  logic [NBRK*DATA_W-1:0] brk_val,
   input  logic [NBRK-1:0]        brk_en,
   output logic                   hit
);

   logic hit_s;

   // OR together every enabled breakpoint whose word equals the instruction.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < NBRK; i++) begin
         hit_s = hit_s | (brk_en[i] & (brk_val[i*DATA_W +: DATA_W] == inst));
      end
   end

   assign hit = hit_s;

endmodule : pda_brk_match

// File: rtl/pda_run_ctrl.sv
// Run controller for the debug port: decides when the core may advance
// (halt low), counts unhalted cycles, and stops on cycle limit, instruction
// breakpoint or counter saturation. STEP mode parks the core in HALTED and
// releases it for fixed-size windows on step_req. Every entry into HALTED
// snapshots the stage visibility words and emits a one-cycle pulse.
module pda_run_ctrl
   import pda_dbg_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 17,
   parameter int NSTAGES = 5,
   parameter int NBRK    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [CNT_W-1:0]          limit,
   input  logic                      step_req,
   input  logic [NBRK*DATA_W-1:0]    brk_val,
   input  logic [NBRK-1:0]           brk_en,
   input  logic [DATA_W-1:0]         inst,
   input  logic [NSTAGES*DATA_W-1:0] stage_visu,
   output logic                      halt,
   output logic [CNT_W-1:0]          cycle_cnt,
   output logic [1:0]                stop_cause,
   output logic [NSTAGES*DATA_W-1:0] snap,
   output logic                      halted_pulse
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Registered state
   run_state_e                  st_r;
   run_mode_e                   mode_r;
   logic [CNT_W-1:0]            limit_r;
   logic [CNT_W-1:0]            cnt_r;
   logic [CNT_W-1:0]            step_left_r;
   stop_cause_e                 cause_r;
   logic [NSTAGES*DATA_W-1:0]   snap_r;
   logic                        pulse_r;
   logic                        halt_r;

   // Next-state values
   run_state_e                  st_s;
   run_mode_e                   mode_s;
   logic [CNT_W-1:0]            limit_s;
   logic [CNT_W-1:0]            cnt_s;
   logic [CNT_W-1:0]            step_left_s;
   stop_cause_e                 cause_s;
   logic                        enter_halt_s;

   // Stop-condition helpers
   logic                        hit_s;
   logic                        running_s;
   logic                        sat_s;
   logic                        lim_en_s;
   logic                        lim_hit_s;
   logic                        brk_s;
   logic                        step_done_s;
   logic [CNT_W:0]              cnt_inc_s;

   pda_brk_match #(
      .DATA_W (DATA_W),
      .NBRK   (NBRK)
   ) u_brk_match (
      .inst    (inst),
      .brk_val (brk_val),
      .brk_en  (brk_en),
      .hit     (hit_s)
   );

   // Evaluate this cycle's stop conditions from the latched run setup.
   // The limit also bounds BREAK runs when it is non-zero, so a breakpoint
   // and the limit can collide in the same cycle; the breakpoint wins.
   always_comb begin
      running_s   = is_running(st_r);
      cnt_inc_s   = {1'b0, cnt_r} + {1'b0, CNT_ONE};
      sat_s       = running_s && (cnt_r == CNT_MAX);
      lim_en_s    = (mode_r == MODE_LIMIT) ||
                    ((mode_r == MODE_BREAK) && (limit_r != CNT_ZERO));
      lim_hit_s   = running_s && lim_en_s && (cnt_inc_s == {1'b0, limit_r});
      brk_s       = running_s && (mode_r == MODE_BREAK) && hit_s;
      step_done_s = (st_r == ST_STEPPING) && (step_left_r == CNT_ONE);
   end

   // Next-state logic: start first, then stop conditions by priority
   // (break, limit, saturation, end of step window), then step requests.
   always_comb begin
      st_s         = st_r;
      mode_s       = mode_r;
      limit_s      = limit_r;
      cnt_s        = cnt_r;
      step_left_s  = step_left_r;
      cause_s      = cause_r;
      enter_halt_s = 1'b0;

      if (start) begin
         mode_s      = run_mode_e'(mode);
         limit_s     = limit;
         cnt_s       = CNT_ZERO;
         cause_s     = CAUSE_NONE;
         step_left_s = CNT_ZERO;
         if (mode == MODE_STEP) begin
            st_s         = ST_HALTED;
            enter_halt_s = 1'b1;
         end else if ((mode == MODE_LIMIT) && (limit == CNT_ZERO)) begin
            st_s         = ST_HALTED;
            cause_s      = CAUSE_LIMIT;
            enter_halt_s = 1'b1;
         end else begin
            st_s = ST_RUN;
         end
      end else begin
         case (st_r)
            ST_IDLE: begin
               st_s = ST_IDLE;
            end
            ST_RUN, ST_STEPPING: begin
               // Saturate instead of wrapping.
               if (sat_s) begin
                  cnt_s = cnt_r;
               end else begin
                  cnt_s = cnt_inc_s[CNT_W-1:0];
               end
               if (st_r == ST_STEPPING) begin
                  step_left_s = step_left_r - CNT_ONE;
               end else begin
                  step_left_s = step_left_r;
               end
               if (brk_s) begin
                  st_s         = ST_HALTED;
                  cause_s      = CAUSE_BREAK;
                  enter_halt_s = 1'b1;
               end else if (lim_hit_s) begin
                  st_s         = ST_HALTED;
                  cause_s      = CAUSE_LIMIT;
                  enter_halt_s = 1'b1;
               end else if (sat_s) begin
                  st_s         = ST_HALTED;
                  cause_s      = CAUSE_SAT;
                  enter_halt_s = 1'b1;
               end else if (step_done_s) begin
                  st_s         = ST_HALTED;
                  cause_s      = CAUSE_NONE;
                  enter_halt_s = 1'b1;
               end else begin
                  st_s = st_r;
               end
            end
            ST_HALTED: begin
               // A step lasts max(limit,1) cycles.
               if ((mode_r == MODE_STEP) && step_req) begin
                  st_s = ST_STEPPING;
                  if (limit_r == CNT_ZERO) begin
                     step_left_s = CNT_ONE;
                  end else begin
                     step_left_s = limit_r;
                  end
               end else begin
                  st_s = ST_HALTED;
               end
            end
            default: begin
               st_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_r        <= ST_IDLE;
         mode_r      <= MODE_FREE;
         limit_r     <= CNT_ZERO;
         cnt_r       <= CNT_ZERO;
         step_left_r <= CNT_ZERO;
         cause_r     <= CAUSE_NONE;
         snap_r      <= {(NSTAGES*DATA_W){1'b0}};
         pulse_r     <= 1'b0;
         halt_r      <= 1'b1;
      end else begin
         st_r        <= st_s;
         mode_r      <= mode_s;
         limit_r     <= limit_s;
         cnt_r       <= cnt_s;
         step_left_r <= step_left_s;
         cause_r     <= cause_s;
         pulse_r     <= enter_halt_s;
         halt_r      <= ~is_running(st_s);
         if (enter_halt_s) begin
            snap_r <= stage_visu;
         end else begin
            snap_r <= snap_r;
         end
      end
   end

   assign halt         = halt_r;
   assign cycle_cnt    = cnt_r;
   assign stop_cause   = cause_r;
   assign snap         = snap_r;
   assign halted_pulse = pulse_r;

endmodule : pda_run_ctrl
